// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Signed ops run on operand magnitudes; signs are restored in a final FIX cycle.
module muldiv_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             cancel,
   input  logic             hi_wr,
   input  logic             lo_wr,
   input  logic [WIDTH-1:0] wr_data,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_t;

   state_t             state;
   logic [2*WIDTH-1:0] acc;       // MUL: {partial product, multiplier}; DIV: {remainder, quotient}
   logic [WIDTH-1:0]   opnd;      // multiplicand or divisor magnitude
   logic [CNT_W-1:0]   cnt;
   logic               is_div;
   logic               qsign;     // sign of product / quotient
   logic               rsign;     // sign of remainder
   logic               zero_div;

   logic               signed_op;
   logic [WIDTH-1:0]   abs1;
   logic [WIDTH-1:0]   abs2;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_trial;
   logic [2*WIDTH-1:0] mul_res;
   logic [WIDTH-1:0]   quo_res;
   logic [WIDTH-1:0]   rem_res;

   // Operand magnitudes, one iteration step of each algorithm, and sign-fixed results.
   always_comb begin
      signed_op = ~op[0];
      abs1      = (signed_op && in1[WIDTH-1]) ? -in1 : in1;
      abs2      = (signed_op && in2[WIDTH-1]) ? -in2 : in2;
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
      div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      div_trial = div_shift - {1'b0, opnd};
      mul_res   = qsign ? -acc : acc;
      quo_res   = zero_div ? '1 : (qsign ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
      rem_res   = rsign ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
   end

   // Control FSM, datapath and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= StIdle;
         acc         <= '0;
         opnd        <= '0;
         cnt         <= '0;
         is_div      <= 1'b0;
         qsign       <= 1'b0;
         rsign       <= 1'b0;
         zero_div    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         hi          <= '0;
         lo          <= '0;
      end else begin
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         unique case (state)
            StIdle: begin
               if (hi_wr) hi <= wr_data;
               if (lo_wr) lo <= wr_data;
               if (start && !cancel) begin
                  busy     <= 1'b1;
                  cnt      <= '0;
                  is_div   <= op[1];
                  qsign    <= signed_op & (in1[WIDTH-1] ^ in2[WIDTH-1]);
                  rsign    <= signed_op & in1[WIDTH-1];
                  zero_div <= op[1] & (in2 == '0);
                  if (op[1]) begin
                     acc   <= {{WIDTH{1'b0}}, abs1};
                     opnd  <= abs2;
                     state <= StDiv;
                  end else begin
                     acc   <= {{WIDTH{1'b0}}, abs2};
                     opnd  <= abs1;
                     state <= StMul;
                  end
               end
            end
            StMul: begin
               if (cancel) begin
                  state <= StIdle;
                  busy  <= 1'b0;
               end else begin
                  acc <= {mul_sum, acc[WIDTH-1:1]};
                  cnt <= cnt + 1'b1;
                  if (cnt == CNT_LAST) state <= StFix;
               end
            end
            StDiv: begin
               if (cancel) begin
                  state <= StIdle;
                  busy  <= 1'b0;
               end else begin
                  // Restoring step: keep the shifted remainder when the trial goes negative.
                  acc <= {(div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0]),
                          acc[WIDTH-2:0], ~div_trial[WIDTH]};
                  cnt <= cnt + 1'b1;
                  if (cnt == CNT_LAST) state <= StFix;
               end
            end
            StFix: begin
               state <= StIdle;
               busy  <= 1'b0;
               if (!cancel) begin
                  done        <= 1'b1;
                  div_by_zero <= is_div & zero_div;
                  if (is_div) begin
                     hi <= rem_res;
                     lo <= quo_res;
                  end else begin
                     hi <= mul_res[2*WIDTH-1:WIDTH];
                     lo <= mul_res[WIDTH-1:0];
                  end
               end
            end
            default: begin
               state <= StIdle;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
